// File: rtl/brick_drawer.sv
// rtl/brick_drawer.sv - rasterises brick slots into registered pixel writes
// Runs a full-field redraw on start, or erases one brick on erase_req.
module brick_drawer #(
  parameter int          X_ORIGIN     = 20,
  parameter int          Y_ORIGIN     = 20,
  parameter int          X_PITCH      = 140,
  parameter int          Y_PITCH      = 60,
  parameter int          BRICK_W      = 120,
  parameter int          BRICK_H      = 40,
  parameter int          NUM_COLS     = 4,
  parameter int          NUM_ROWS     = 3,
  parameter logic [2:0]  BRICK_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        erase_req,
  input  logic [3:0]  erase_num,
  input  logic [11:0] brick_alive,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic MODE_ERASE = 1'b0;
  localparam logic MODE_FULL  = 1'b1;

  localparam int         NUM_BRICKS = NUM_COLS * NUM_ROWS;
  localparam logic [3:0] LAST_N     = 4'(NUM_BRICKS - 1);
  localparam logic [6:0] LAST_CX    = 7'(BRICK_W - 1);
  localparam logic [5:0] LAST_CY    = 6'(BRICK_H - 1);

  logic [1:0] state_q, state_d;
  logic       mode_q, mode_d;
  logic [3:0] n_q, n_d;
  logic [6:0] cx_q, cx_d;
  logic [5:0] cy_q, cy_d;
  logic [9:0] x0_q, x0_d;
  logic [9:0] y0_q, y0_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;

  logic [9:0] col_x0, row_y0;
  logic       last_px;

  // Origins are per-slot constants, so the pitch products fold away at elaboration.
  always_comb begin
    col_x0 = 10'(X_ORIGIN);
    case (n_q[1:0])
      2'd1:    col_x0 = 10'(X_ORIGIN + X_PITCH);
      2'd2:    col_x0 = 10'(X_ORIGIN + 2 * X_PITCH);
      2'd3:    col_x0 = 10'(X_ORIGIN + 3 * X_PITCH);
      default: col_x0 = 10'(X_ORIGIN);
    endcase
    row_y0 = 10'(Y_ORIGIN);
    case (n_q[3:2])
      2'd1:    row_y0 = 10'(Y_ORIGIN + Y_PITCH);
      2'd2:    row_y0 = 10'(Y_ORIGIN + 2 * Y_PITCH);
      default: row_y0 = 10'(Y_ORIGIN);
    endcase
  end

  assign last_px = (cx_q == LAST_CX) && (cy_q == LAST_CY);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    n_d      = n_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = MODE_FULL;
          n_d     = 4'd0;
          state_d = S_LOAD;
        end else if (erase_req && (erase_num < 4'(NUM_BRICKS))) begin
          mode_d  = MODE_ERASE;
          n_d     = erase_num;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        x0_d     = col_x0;
        y0_d     = row_y0;
        cx_d     = 7'd0;
        cy_d     = 6'd0;
        colour_d = ((mode_q == MODE_FULL) && brick_alive[n_q]) ? BRICK_COLOUR : BG_COLOUR;
        // The first pixel of the brick is registered on the way into DRAW.
        x_d      = col_x0;
        y_d      = row_y0;
        plot_d   = 1'b1;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (last_px) begin
          cx_d = 7'd0;
          cy_d = 6'd0;
          if ((mode_q == MODE_FULL) && (n_q != LAST_N)) begin
            n_d     = n_q + 4'd1;
            state_d = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          if (cx_q == LAST_CX) begin
            cx_d = 7'd0;
            cy_d = cy_q + 6'd1;
          end else begin
            cx_d = cx_q + 7'd1;
          end
          x_d    = x0_q + 10'(cx_d);
          y_d    = y0_q + 10'(cy_d);
          plot_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_ERASE;
      n_q      <= 4'd0;
      cx_q     <= 7'd0;
      cy_q     <= 6'd0;
      x0_q     <= 10'd0;
      y0_q     <= 10'd0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      n_q      <= n_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);

endmodule
